timer_nch: RTL and testbench

//  N-channel programmable down-counter/timer peripheral. Generalised successor to the
//  3-channel bus counter: one clock, per-channel prescaler, four modes (one-shot, periodic,

---
 rtl/timer_nch.sv | 206 ++++++++++++++++++++
 tb/tb_timer_nch.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_nch.sv
// N-channel programmable down-counter/timer with per-channel prescaler,
// one-shot/periodic/square/PWM modes, sticky flags and maskable interrupts.

module timer_nch_ch #(
    parameter int WIDTH = 32,
    parameter int PSC_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_ctrl,
    input  logic             wr_load,
    input  logic             wr_cmp,
    input  logic             wr_stat,
    input  logic [31:0]      wdata,
    output logic [31:0]      ctrl_rd,
    output logic [WIDTH-1:0] count_rd,
    output logic [WIDTH-1:0] cmp_rd,
    output logic             flag_rd,
    output logic             out_rd,
    output logic             irq
);

    localparam logic [1:0] MODE_ONE = 2'b00;
    localparam logic [1:0] MODE_PER = 2'b01;
    localparam logic [1:0] MODE_SQR = 2'b10;
    localparam logic [1:0] MODE_PWM = 2'b11;

    logic             en_q;
    logic             ie_q;
    logic [1:0]       mode_q;
    logic [PSC_W-1:0] psc_set_q;
    logic [PSC_W-1:0] psc_q;
    logic [WIDTH-1:0] load_q;
    logic [WIDTH-1:0] cmp_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_nxt;
    logic             flag_q;
    logic             out_q;

    logic tick;
    logic event_hit;
    logic start;
    logic start_out;

    assign tick      = en_q && (psc_q == psc_set_q);
    // A CTRL write on a tick edge discards that tick entirely.
    assign event_hit = tick && !wr_ctrl && (count_q == '0);
    assign start     = wr_ctrl && wdata[0] && !en_q;
    assign start_out = (wdata[2:1] == MODE_PWM) ? (load_q < cmp_q) : 1'b0;

    always_comb begin
        count_nxt = count_q;
        if (tick) begin
            if (count_q != '0) begin
                count_nxt = count_q - WIDTH'(1);
            end else if (mode_q != MODE_ONE) begin
                count_nxt = load_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            mode_q    <= MODE_ONE;
            psc_set_q <= '0;
            psc_q     <= '0;
            load_q    <= '0;
            cmp_q     <= '0;
            count_q   <= '0;
            flag_q    <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            if (wr_load) begin
                load_q <= wdata[WIDTH-1:0];
            end
            if (wr_cmp) begin
                cmp_q <= wdata[WIDTH-1:0];
            end

            if (event_hit) begin
                flag_q <= 1'b1;
            end else if (wr_stat && wdata[0]) begin
                flag_q <= 1'b0;
            end

            if (wr_ctrl) begin
                en_q      <= wdata[0];
                mode_q    <= wdata[2:1];
                ie_q      <= wdata[3];
                psc_set_q <= wdata[8 +: PSC_W];
                if (start) begin
                    count_q <= load_q;
                    psc_q   <= '0;
                    out_q   <= start_out;
                end
            end else if (en_q) begin
                psc_q   <= tick ? '0 : psc_q + PSC_W'(1);
                count_q <= count_nxt;
                unique case (mode_q)
                    MODE_ONE: begin
                        if (event_hit) begin
                            en_q  <= 1'b0;
                            out_q <= 1'b1;
                        end
                    end
                    MODE_PER: out_q <= event_hit;
                    MODE_SQR: begin
                        if (event_hit) begin
                            out_q <= ~out_q;
                        end
                    end
                    MODE_PWM: out_q <= (count_nxt < cmp_q);
                endcase
            end
        end
    end

    always_comb begin
        ctrl_rd             = '0;
        ctrl_rd[0]          = en_q;
        ctrl_rd[2:1]        = mode_q;
        ctrl_rd[3]          = ie_q;
        ctrl_rd[8 +: PSC_W] = psc_set_q;
    end

    assign count_rd = count_q;
    assign cmp_rd   = cmp_q;
    assign flag_rd  = flag_q;
    assign out_rd   = out_q;
    assign irq      = flag_q & ie_q;

endmodule

module timer_nch #(
    parameter int NCH   = 4,
    parameter int WIDTH = 32,
    parameter int PSC_W = 8,
    localparam int AW   = $clog2(NCH) + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [AW-1:0]  addr,
    input  logic [31:0]    wdata,
    output logic [31:0]    rdata,
    output logic [NCH-1:0] cnt_out,
    output logic [NCH-1:0] irq,
    output logic           irq_any
);

    logic [4:0] ch_sel;
    logic [1:0] reg_sel;

    logic [31:0]      ctrl_v  [NCH];
    logic [WIDTH-1:0] count_v [NCH];
    logic [WIDTH-1:0] cmp_v   [NCH];
    logic [NCH-1:0]   flag_v;

    // Shift rather than slice so a single-channel build has no empty field.
    assign ch_sel  = 5'(addr >> 2);
    assign reg_sel = addr[1:0];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic hit;

        assign hit = we && (ch_sel == 5'(g));

        timer_nch_ch #(
            .WIDTH (WIDTH),
            .PSC_W (PSC_W)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .wr_ctrl  (hit && (reg_sel == 2'd0)),
            .wr_load  (hit && (reg_sel == 2'd1)),
            .wr_cmp   (hit && (reg_sel == 2'd2)),
            .wr_stat  (hit && (reg_sel == 2'd3)),
            .wdata    (wdata),
            .ctrl_rd  (ctrl_v[g]),
            .count_rd (count_v[g]),
            .cmp_rd   (cmp_v[g]),
            .flag_rd  (flag_v[g]),
            .out_rd   (cnt_out[g]),
            .irq      (irq[g])
        );
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NCH; i++) begin
            if (ch_sel == 5'(i)) begin
                unique case (reg_sel)
                    2'd0: rdata = ctrl_v[i];
                    2'd1: rdata = 32'(count_v[i]);
                    2'd2: rdata = 32'(cmp_v[i]);
                    2'd3: rdata = {31'b0, flag_v[i]};
                endcase
            end
        end
    end

    assign irq_any = |irq;

endmodule

// File: tb/tb_timer_nch.sv
// Directed bench for timer_nch: register table plus mode sequences.
// A second 3-channel instance exposes the out-of-range channel case.

module tb_timer_nch;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  cnt_out;
    logic [3:0]  irq;
    logic        irq_any;
    logic [31:0] rdata_b;
    logic [2:0]  cnt_out_b;
    logic [2:0]  irq_b;
    logic        irq_any_b;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    timer_nch dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .cnt_out (cnt_out),
        .irq     (irq),
        .irq_any (irq_any)
    );

    timer_nch #(.NCH(3)) dut_b (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata_b),
        .cnt_out (cnt_out_b),
        .irq     (irq_b),
        .irq_any (irq_any_b)
    );

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        we    = 1'b1;
        addr  = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e,
                      input string name);
        addr = a;
        #1;
        check(name, rdata, e);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        we  = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        we    = 1'b0;
        addr  = '0;
        wdata = '0;

        // reset state
        do_reset();
        for (int a = 0; a < 16; a++) rd(4'(a), 32'h0, "reset_rd");
        check("reset_cnt_out", {28'b0, cnt_out}, 32'h0);
        check("reset_irq", {28'b0, irq}, 32'h0);
        chk1("reset_irq_any", irq_any, 1'b0);

        // register table
        vecs[0] = '{1'b1, 4'd0,  32'h0000_FF0E, 4'd0,  32'h0000_FF0E, "ctrl_fields"};
        vecs[1] = '{1'b1, 4'd0,  32'hFFFF_FFFE, 4'd0,  32'h0000_FF0E, "ctrl_mask"};
        vecs[2] = '{1'b1, 4'd0,  32'h0000_0000, 4'd0,  32'h0000_0000, "ctrl_clear"};
        vecs[3] = '{1'b1, 4'd5,  32'h1234_5678, 4'd5,  32'h0000_0000, "load_shadow"};
        vecs[4] = '{1'b1, 4'd6,  32'hDEAD_BEEF, 4'd6,  32'hDEAD_BEEF, "cmp_rw"};
        vecs[5] = '{1'b1, 4'd11, 32'h0000_0001, 4'd11, 32'h0000_0000, "status_noflag"};
        vecs[6] = '{1'b0, 4'd0,  32'h0000_0000, 4'd10, 32'h0000_0000, "cmp_other_ch"};
        vecs[7] = '{1'b1, 4'd9,  32'hFFFF_FFFF, 4'd9,  32'h0000_0000, "load2_shadow"};
        vecs[8] = '{1'b1, 4'd14, 32'h0000_00FF, 4'd14, 32'h0000_00FF, "cmp3_rw"};
        vecs[9] = '{1'b1, 4'd12, 32'h0000_0A06, 4'd12, 32'h0000_0A06, "ctrl3_rw"};
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].we) wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].raddr, vecs[i].exp, vecs[i].name);
        end

        // periodic: LOAD=4, PSC=0 -> 1-clk pulse every 5 clks
        do_reset();
        wr(4'd1, 32'd4);
        wr(4'd0, 32'h3);
        rd(4'd1, 32'd4, "periodic_start_count");
        for (int k = 1; k <= 15; k++) begin
            tick();
            chk1("periodic_out", cnt_out[0], (k % 5) == 0);
        end
        rd(4'd3, 32'd1, "periodic_flag");
        chk1("periodic_irq_masked", irq[0], 1'b0);

        // one-shot: LOAD=2, PSC=3, IE -> fires after 12 clks
        do_reset();
        wr(4'd5, 32'd2);
        wr(4'd4, 32'h309);
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk1("oneshot_out", cnt_out[1], k == 12);
            if (k == 11) chk1("oneshot_irq_early", irq[1], 1'b0);
        end
        chk1("oneshot_irq", irq[1], 1'b1);
        chk1("oneshot_irq_any", irq_any, 1'b1);
        rd(4'd4, 32'h308, "oneshot_en_off");
        wr(4'd4, 32'h300);
        chk1("ie_mask_irq", irq[1], 1'b0);
        rd(4'd7, 32'd1, "ie_mask_flag_kept");
        wr(4'd4, 32'h308);
        chk1("ie_unmask_irq", irq[1], 1'b1);
        wr(4'd7, 32'd1);
        chk1("status_clr_irq", irq[1], 1'b0);
        chk1("status_clr_irq_any", irq_any, 1'b0);
        chk1("oneshot_out_held", cnt_out[1], 1'b1);

        // square: LOAD=1, PSC=1; LOAD=3 mid-count applies after reload
        do_reset();
        wr(4'd9, 32'd1);
        wr(4'd8, 32'h105);
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk1("square_out", cnt_out[2], k >= 4);
        end
        wr(4'd9, 32'd3);
        chk1("square_out_k6", cnt_out[2], 1'b1);
        for (int k = 7; k <= 20; k++) begin
            tick();
            chk1("square_reload", cnt_out[2], (k < 8) || (k >= 16));
            if (k == 9) rd(4'd9, 32'd3, "square_new_load");
        end

        // PWM: LOAD=9, CMP=3 -> high 3 of 10
        do_reset();
        wr(4'd13, 32'd9);
        wr(4'd14, 32'd3);
        wr(4'd12, 32'h7);
        chk1("pwm_start_out", cnt_out[3], 1'b0);
        for (int k = 1; k <= 20; k++) begin
            tick();
            chk1("pwm_out", cnt_out[3], (k % 10) >= 7);
        end
        wr(4'd14, 32'd0);
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk1("pwm_cmp0", cnt_out[3], 1'b0);
        end
        wr(4'd14, 32'd10);
        tick();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk1("pwm_cmp_gt_load", cnt_out[3], 1'b1);
        end

        // STATUS clear colliding with an event
        do_reset();
        wr(4'd1, 32'd4);
        wr(4'd0, 32'h3);
        repeat (9) tick();
        wr(4'd3, 32'd1);
        chk1("clr_vs_event_out", cnt_out[0], 1'b1);
        rd(4'd3, 32'd1, "clr_vs_event_flag");
        wr(4'd3, 32'd1);
        rd(4'd3, 32'd0, "clr_plain_flag");

        // reset mid-count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk1("midrst_out", cnt_out[0], 1'b0);
        rd(4'd0, 32'd0, "midrst_ctrl");
        rd(4'd1, 32'd0, "midrst_count");

        // CTRL write on a tick edge, then stop
        do_reset();
        wr(4'd1, 32'd4);
        wr(4'd0, 32'h103);
        tick();
        wr(4'd0, 32'h103);
        rd(4'd1, 32'd4, "ctrl_tick_discard");
        tick();
        rd(4'd1, 32'd3, "ctrl_keep_psc");
        wr(4'd0, 32'h102);
        repeat (6) tick();
        rd(4'd1, 32'd3, "stop_freeze");

        // out-of-range channel on the 3-channel instance
        do_reset();
        wr(4'd12, 32'h30F);
        rd(4'd12, 32'h30F, "ch3_exists");
        check("oob_ctrl", rdata_b, 32'h0);
        wr(4'd13, 32'd5);
        addr = 4'd13;
        #1;
        check("oob_load", rdata_b, 32'h0);
        check("oob_cnt_out", {29'b0, cnt_out_b}, 32'h0);
        chk1("oob_irq_any", irq_any_b, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
